chroma_intra_mode_sched: RTL

Sequencer and mode-decision controller for the 8x8 chroma SAD datapath in the intra-prediction path. On a start request it runs the shared SAD unit twice: once for Cb, then once for Cr. It selects the residual source through comp_sel, samples the unit's three per-mode SADs after a fixed latency, and accumulates Cb+Cr cost per mode. It then picks the lowest-cost chroma intra mode and reports it to the mode-decision stage.

---
 rtl/chroma_intra_mode_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/chroma_intra_mode_sched.sv
// chroma_intra_mode_sched
//   Sequences the shared 8x8 chroma SAD unit over Cb then Cr, accumulates the
//   per-mode Cb+Cr cost and picks the cheapest H.264 chroma intra mode.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request a decision (accepted only in IDLE)
//   abort               cancel a running decision, no done pulse
//   sad_v/h/dc          per-mode SADs from the SAD unit (8-bit unsigned)
//   sad_en              one-cycle enable to the SAD unit per component
//   comp_sel            residual source select, 0=Cb 1=Cr
//   busy                operation in flight (cycle after accept .. done cycle)
//   done                one-cycle pulse, results valid
//   best_mode/best_sad  winning mode (0=DC 1=H 2=V) and its cost
//   cost_v/h/dc         Cb+Cr cost per mode
module chroma_intra_mode_sched #(
    parameter int SAD_LAT = 1,
    parameter int ACC_W   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       sad_v,
    input  logic [7:0]       sad_h,
    input  logic [7:0]       sad_dc,
    output logic             sad_en,
    output logic             comp_sel,
    output logic             busy,
    output logic             done,
    output logic [1:0]       best_mode,
    output logic [ACC_W-1:0] best_sad,
    output logic [ACC_W-1:0] cost_v,
    output logic [ACC_W-1:0] cost_h,
    output logic [ACC_W-1:0] cost_dc
);

    localparam int               CNT_W    = (SAD_LAT > 1) ? $clog2(SAD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAD_LAT - 1);

    localparam logic [1:0] MODE_DC = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_V  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, LOAD_CB, WAIT_CB, LOAD_CR, WAIT_CR, DECIDE, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc_v, acc_h, acc_dc;
    logic [1:0]       min_mode;
    logic [ACC_W-1:0] min_sad;

    // Start from DC and only displace on strictly lower cost, so ties resolve
    // DC first, then horizontal, then vertical.
    always_comb begin
        min_mode = MODE_DC;
        min_sad  = acc_dc;
        if (acc_h < min_sad) begin
            min_mode = MODE_H;
            min_sad  = acc_h;
        end
        if (acc_v < min_sad) begin
            min_mode = MODE_V;
            min_sad  = acc_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_v     <= '0;
            acc_h     <= '0;
            acc_dc    <= '0;
            sad_en    <= 1'b0;
            comp_sel  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            best_mode <= '0;
            best_sad  <= '0;
            cost_v    <= '0;
            cost_h    <= '0;
            cost_dc   <= '0;
        end else begin
            sad_en <= 1'b0;
            done   <= 1'b0;
            if (state != IDLE && abort) begin
                // Results are untouched; accumulators are cleared on next start.
                state    <= IDLE;
                busy     <= 1'b0;
                comp_sel <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LOAD_CB;
                            sad_en   <= 1'b1;
                            comp_sel <= 1'b0;
                            busy     <= 1'b1;
                            acc_v    <= '0;
                            acc_h    <= '0;
                            acc_dc   <= '0;
                        end
                    end
                    LOAD_CB: begin
                        state <= WAIT_CB;
                        cnt   <= '0;
                    end
                    WAIT_CB: begin
                        if (cnt == CNT_LAST) begin
                            acc_v    <= ACC_W'(sad_v);
                            acc_h    <= ACC_W'(sad_h);
                            acc_dc   <= ACC_W'(sad_dc);
                            state    <= LOAD_CR;
                            sad_en   <= 1'b1;
                            comp_sel <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOAD_CR: begin
                        state <= WAIT_CR;
                        cnt   <= '0;
                    end
                    WAIT_CR: begin
                        if (cnt == CNT_LAST) begin
                            acc_v    <= acc_v + ACC_W'(sad_v);
                            acc_h    <= acc_h + ACC_W'(sad_h);
                            acc_dc   <= acc_dc + ACC_W'(sad_dc);
                            state    <= DECIDE;
                            comp_sel <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DECIDE: begin
                        cost_v    <= acc_v;
                        cost_h    <= acc_h;
                        cost_dc   <= acc_dc;
                        best_mode <= min_mode;
                        best_sad  <= min_sad;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
